// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch definitions: FSM state encoding, reset PC default and the
// unknown-input detector used by the sticky error flag.
package fetch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int          PC_STEP_DEFAULT  = 2;

  // Reduction XOR goes to X whenever any bit is X or Z.
  function automatic logic has_unknown(input logic [3:0] v);
    return ((^v) === 1'bx);
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Fetch-side bundle: execute redirect, instruction-memory read handshake and
// the fetch-to-decode valid/ready pair.
interface fetch_redirect_unit_if;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_inc;
  logic        id_ready;
  logic        halt;

  modport master (
    input  redirect, redirect_pc, imem_stall, imem_done, imem_data, id_ready, halt,
    output imem_rd, imem_addr, if_valid, if_instr, if_pc_inc
  );

  modport slave (
    output redirect, redirect_pc, imem_stall, imem_done, imem_data, id_ready, halt,
    input  imem_rd, imem_addr, if_valid, if_instr, if_pc_inc
  );
endinterface

// File: rtl/fetch_redirect_unit_cla_16b.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead blocks whose
// group generate/propagate feed a second lookahead level.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  bc;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_blk
      localparam int B = 4 * gi;
      assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[gi] = &p[B+3:B];
      // In-block carries come straight from the block carry-in, never from c.
      assign c[B]   = bc[gi];
      assign c[B+1] = g[B] | (p[B] & bc[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & bc[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & bc[gi]);
    end
  endgenerate

  assign bc[0] = c_in;
  assign bc[1] = gg[0] | (gp[0] & c_in);
  assign bc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
  assign bc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & c_in);
  assign bc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

  assign sum   = p ^ c;
  assign c_out = bc[4];

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: owns the PC, issues imem reads, holds the
// fetched word for decode and squashes wrong-path fetches on redirect.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_redirect_unit_if.master fb,
  output logic                 err
);

  localparam logic [15:0] STEP16 = 16'(PC_STEP);

  fetch_state_t state_reg, state_next;
  logic [15:0]  pc_reg, pc_next;
  logic         squash_reg, squash_next;
  logic         if_valid_reg, if_valid_next;
  logic [15:0]  if_instr_reg, if_instr_next;
  logic [15:0]  if_pc_inc_reg, if_pc_inc_next;
  logic         err_reg, err_next;
  logic [15:0]  pc_inc;
  logic         pc_carry_unused;

  cla_16b u_pc_add (
    .a     (pc_reg),
    .b     (STEP16),
    .c_in  (1'b0),
    .sum   (pc_inc),
    .c_out (pc_carry_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      squash_reg    <= 1'b0;
      if_valid_reg  <= 1'b0;
      if_instr_reg  <= 16'h0000;
      if_pc_inc_reg <= 16'h0000;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      squash_reg    <= squash_next;
      if_valid_reg  <= if_valid_next;
      if_instr_reg  <= if_instr_next;
      if_pc_inc_reg <= if_pc_inc_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    squash_next    = squash_reg;
    if_valid_next  = if_valid_reg;
    if_instr_next  = if_instr_reg;
    if_pc_inc_next = if_pc_inc_reg;

    err_next = err_reg
             | has_unknown({fb.redirect, fb.imem_stall, fb.imem_done, fb.id_ready})
             | ((fb.imem_done === 1'b1) && (state_reg != S_WAIT));

    unique case (state_reg)
      S_REQ: begin
        if (fb.redirect)        pc_next = fb.redirect_pc;
        else if (!fb.imem_stall) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (fb.imem_done) begin
          if (squash_reg || fb.redirect) begin
            squash_next = 1'b0;
            state_next  = S_REQ;
            if (fb.redirect) pc_next = fb.redirect_pc;
          end else begin
            if_instr_next  = fb.imem_data;
            if_pc_inc_next = pc_inc;
            pc_next        = pc_inc;
            if_valid_next  = 1'b1;
            state_next     = S_HOLD;
          end
        end else if (fb.redirect) begin
          // Data for the old address is still in flight; drop it on arrival.
          pc_next     = fb.redirect_pc;
          squash_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (fb.redirect) begin
          if_valid_next = 1'b0;
          pc_next       = fb.redirect_pc;
          state_next    = S_REQ;
        end else if (fb.id_ready) begin
          if_valid_next = 1'b0;
          state_next    = fb.halt ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        if_valid_next = 1'b0;
      end
      default: state_next = S_REQ;
    endcase
  end

  assign fb.imem_rd   = rst_n & (state_reg == S_REQ) & ~fb.redirect;
  assign fb.imem_addr = pc_reg;
  assign fb.if_valid  = if_valid_reg;
  assign fb.if_instr  = if_instr_reg;
  assign fb.if_pc_inc = if_pc_inc_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: sequential fetch, stall, redirects,
// halt, PC wrap and sticky error, on two instances (RESET_PC 0000 and FFFE).
module tb_fetch_redirect_unit;

  logic clk;
  logic rst_n;
  logic err0, err1;
  int   vectors;
  int   miscompares;

  fetch_redirect_unit_if b0 ();
  fetch_redirect_unit_if b1 ();

  fetch_redirect_unit #(.RESET_PC(16'h0000), .PC_STEP(2)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .fb    (b0),
    .err   (err0)
  );

  fetch_redirect_unit #(.RESET_PC(16'hFFFE), .PC_STEP(2)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .fb    (b1),
    .err   (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [15:0] data_tab [3];

  initial begin
    vectors     = 0;
    miscompares = 0;
    data_tab[0] = 16'h00A1;
    data_tab[1] = 16'h00B2;
    data_tab[2] = 16'h00C3;

    rst_n = 1'b0;
    b0.redirect = 1'b0; b0.redirect_pc = 16'h0000; b0.imem_stall = 1'b0;
    b0.imem_done = 1'b0; b0.imem_data = 16'h0000; b0.id_ready = 1'b1; b0.halt = 1'b0;
    b1.redirect = 1'b0; b1.redirect_pc = 16'h0000; b1.imem_stall = 1'b1;
    b1.imem_done = 1'b0; b1.imem_data = 16'h0000; b1.id_ready = 1'b0; b1.halt = 1'b0;

    // Reset state.
    #2;
    chk("rst_rd", b0.imem_rd, 1'b0);
    chk("rst_valid", b0.if_valid, 1'b0);
    chk("rst_instr", b0.if_instr, 16'h0000);
    chk("rst_pc_inc", b0.if_pc_inc, 16'h0000);
    chk("rst_err", err0, 1'b0);
    chk("rst_addr", b0.imem_addr, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    settle();

    // Three zero-stall fetches, one transfer every three cycles.
    for (int k = 0; k < 3; k++) begin
      chk("seq_rd", b0.imem_rd, 1'b1);
      chk("seq_addr", b0.imem_addr, 16'(2 * k));
      tick();
      chk("seq_wait_rd", b0.imem_rd, 1'b0);
      b0.imem_done = 1'b1; b0.imem_data = data_tab[k];
      tick();
      b0.imem_done = 1'b0;
      chk("seq_valid", b0.if_valid, 1'b1);
      chk("seq_instr", b0.if_instr, data_tab[k]);
      chk("seq_pc_inc", b0.if_pc_inc, 16'(2 * k + 2));
      $display("fetch u0 instr=%h pc_inc=%h", b0.if_instr, b0.if_pc_inc);
      tick();
    end
    chk("seq_err", err0, 1'b0);

    // Stall in S_REQ for four cycles, accepted on the fifth.
    b0.imem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("stall_rd", b0.imem_rd, 1'b1);
      chk("stall_addr", b0.imem_addr, 16'h0006);
      chk("stall_valid", b0.if_valid, 1'b0);
      tick();
    end
    b0.imem_stall = 1'b0;
    settle();
    chk("stall_rd5", b0.imem_rd, 1'b1);
    chk("stall_addr5", b0.imem_addr, 16'h0006);
    tick();
    chk("stall_wait_rd", b0.imem_rd, 1'b0);
    chk("stall_wait_valid", b0.if_valid, 1'b0);
    b0.imem_done = 1'b1; b0.imem_data = 16'h00D4;
    tick();
    b0.imem_done = 1'b0;
    chk("stall_instr", b0.if_instr, 16'h00D4);
    chk("stall_pc_inc", b0.if_pc_inc, 16'h0008);
    $display("fetch u0 instr=%h pc_inc=%h", b0.if_instr, b0.if_pc_inc);
    b0.id_ready = 1'b0;
    tick();
    chk("hold_valid", b0.if_valid, 1'b1);
    chk("hold_instr", b0.if_instr, 16'h00D4);
    b0.id_ready = 1'b1;
    tick();
    chk("xfer_valid", b0.if_valid, 1'b0);
    chk("xfer_addr", b0.imem_addr, 16'h0008);

    // Redirect while waiting; the late DEAD word is dropped.
    tick();
    b0.redirect = 1'b1; b0.redirect_pc = 16'h0100;
    tick();
    b0.redirect = 1'b0;
    chk("sq_rd", b0.imem_rd, 1'b0);
    chk("sq_valid", b0.if_valid, 1'b0);
    tick();
    b0.imem_done = 1'b1; b0.imem_data = 16'hDEAD;
    tick();
    b0.imem_done = 1'b0;
    chk("sq_drop_valid", b0.if_valid, 1'b0);
    chk("sq_rd_next", b0.imem_rd, 1'b1);
    chk("sq_addr_next", b0.imem_addr, 16'h0100);
    tick();
    b0.imem_done = 1'b1; b0.imem_data = 16'h1234;
    tick();
    b0.imem_done = 1'b0;
    chk("sq_instr", b0.if_instr, 16'h1234);
    chk("sq_pc_inc", b0.if_pc_inc, 16'h0102);
    $display("fetch u0 instr=%h pc_inc=%h", b0.if_instr, b0.if_pc_inc);

    // Redirect in S_HOLD beats id_ready and halt.
    b0.redirect = 1'b1; b0.redirect_pc = 16'h0040; b0.halt = 1'b1;
    tick();
    b0.redirect = 1'b0; b0.halt = 1'b0;
    settle();
    chk("hr_valid", b0.if_valid, 1'b0);
    chk("hr_rd", b0.imem_rd, 1'b1);
    chk("hr_addr", b0.imem_addr, 16'h0040);
    tick();
    b0.imem_done = 1'b1; b0.imem_data = 16'h5555;
    tick();
    b0.imem_done = 1'b0;
    chk("hr_instr", b0.if_instr, 16'h5555);
    chk("hr_pc_inc", b0.if_pc_inc, 16'h0042);
    $display("fetch u0 instr=%h pc_inc=%h", b0.if_instr, b0.if_pc_inc);

    // Halting transfer; redirects ignored afterwards.
    b0.halt = 1'b1;
    tick();
    b0.halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b0.redirect = i[0]; b0.redirect_pc = 16'h0200;
      settle();
      chk("halt_rd", b0.imem_rd, 1'b0);
      chk("halt_valid", b0.if_valid, 1'b0);
      tick();
    end
    b0.redirect = 1'b0;
    chk("halt_err", err0, 1'b0);
    chk("halt_addr", b0.imem_addr, 16'h0042);
    rst_n = 1'b0;
    settle();
    chk("rst2_rd", b0.imem_rd, 1'b0);
    chk("rst2_addr", b0.imem_addr, 16'h0000);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rst2_resume_rd", b0.imem_rd, 1'b1);
    chk("rst2_resume_addr", b0.imem_addr, 16'h0000);

    // Wrap on the FFFE-reset instance, then a stray done in S_HOLD.
    chk("wrap_rd", b1.imem_rd, 1'b1);
    chk("wrap_addr", b1.imem_addr, 16'hFFFE);
    b1.imem_stall = 1'b0;
    tick();
    b1.imem_done = 1'b1; b1.imem_data = 16'h7777;
    tick();
    b1.imem_done = 1'b0;
    chk("wrap_instr", b1.if_instr, 16'h7777);
    chk("wrap_pc_inc", b1.if_pc_inc, 16'h0000);
    chk("wrap_err", err1, 1'b0);
    $display("fetch u1 instr=%h pc_inc=%h", b1.if_instr, b1.if_pc_inc);
    b1.imem_done = 1'b1;
    tick();
    b1.imem_done = 1'b0;
    chk("err_set", err1, 1'b1);
    b1.id_ready = 1'b1;
    tick();
    chk("wrap_next_addr", b1.imem_addr, 16'h0000);
    chk("wrap_next_rd", b1.imem_rd, 1'b1);
    b1.imem_stall = 1'b1;
    tick();
    tick();
    chk("err_sticky", err1, 1'b1);
    chk("err_other", err0, 1'b0);
    rst_n = 1'b0;
    settle();
    chk("err_clear", err1, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
